oflow_fsm_write: RTL and testbench

OFLOW_FSM_WRITE -- requirements
Module: oflow_fsm_write

---
 rtl/oflow_fsm_write_pkg.sv | 25 ++
 rtl/oflow_fsm_write_slot_ptr.sv | 32 +++
 rtl/oflow_fsm_write.sv | 111 +++++++++++
 tb/tb_oflow_fsm_write.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/oflow_fsm_write_pkg.sv
// Shared widths, limits and write-FSM state encoding for the oflow history buffer.
// Widths are derived from MAX_BBOX_PER_FRAME so the block rescales with one edit.
`default_nettype none

package oflow_MEM_buffer_define;

    localparam int MAX_BBOX_PER_FRAME          = 32;
    localparam int NUM_SLOTS                   = 5;
    localparam int TOTAL_FRAME_NUM_WIDTH       = 8;
    localparam int NUM_OF_HISTORY_FRAMES_WIDTH = 3;
    localparam int SLOT_WIDTH                  = 3;
    // Two bboxes share one buffer line, so a frame spans MAX/2 lines.
    localparam int OFFSET_WIDTH                = $clog2(MAX_BBOX_PER_FRAME / 2);
    localparam int ADDR_WIDTH                  = $clog2(MAX_BBOX_PER_FRAME + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } write_state_t;

endpackage

`default_nettype wire

// File: rtl/oflow_fsm_write_slot_ptr.sv
// Wrapping history-slot pointer: advances once per frame, restarts on frame 0.
// Wraps after the last configured slot and never leaves the physical slot range.
`default_nettype none

module oflow_fsm_write_slot_ptr
    import oflow_MEM_buffer_define::*;
(
    input  logic                                   clk,
    input  logic                                   reset_N,
    input  logic                                   advance,
    input  logic                                   restart,
    input  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] last_slot,
    output logic [SLOT_WIDTH-1:0]                  slot
);

    logic wrap;

    assign wrap = restart
               || (slot >= last_slot)
               || (slot >= SLOT_WIDTH'(NUM_SLOTS - 1));

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            slot <= '0;
        end else if (advance) begin
            slot <= wrap ? '0 : slot + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/oflow_fsm_write.sv
// Write-side FSM of the oflow history buffer: stores one frame of bboxes per slot.
// Build option OFLOW_FSM_WRITE_OVERFLOW_EN enables the sticky overflow flag.
`default_nettype none

module oflow_fsm_write
    import oflow_MEM_buffer_define::*;
(
    input  logic                                   clk,
    input  logic                                   reset_N,
    input  logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_num,
    input  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames,
    input  logic                                   start_write,
    input  logic                                   bbox_valid,
    input  logic                                   bbox_last,
    output logic                                   bbox_ready,
    output logic                                   we,
    output logic [SLOT_WIDTH-1:0]                  frame_to_write,
    output logic [OFFSET_WIDTH-1:0]                offset,
    output logic                                   half_sel,
    output logic [ADDR_WIDTH-1:0]                  end_pointers [NUM_SLOTS],
    output logic                                   done_write,
    output logic                                   overflow
);

    write_state_t          state;
    logic [ADDR_WIDTH-1:0] bbox_cnt;
    logic [SLOT_WIDTH-1:0] slot;
    logic                  start_frame;
    logic                  handshake;
    logic                  room;

    assign start_frame = (state == ST_IDLE) && start_write;
    assign handshake   = bbox_valid && bbox_ready;
    assign room        = bbox_cnt < ADDR_WIDTH'(MAX_BBOX_PER_FRAME);

    // History depth is only looked at on the IDLE->CLEAR step.
    oflow_fsm_write_slot_ptr u_slot_ptr (
        .clk       (clk),
        .reset_N   (reset_N),
        .advance   (start_frame),
        .restart   (frame_num == '0),
        .last_slot (num_of_history_frames),
        .slot      (slot)
    );

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state          <= ST_IDLE;
            bbox_cnt       <= '0;
            bbox_ready     <= 1'b0;
            we             <= 1'b0;
            frame_to_write <= '0;
            offset         <= '0;
            half_sel       <= 1'b0;
            done_write     <= 1'b0;
            overflow       <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                end_pointers[i] <= '0;
            end
        end else begin
            we         <= 1'b0;
            done_write <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_write) begin
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    end_pointers[slot] <= '0;
                    bbox_cnt           <= '0;
                    overflow           <= 1'b0;
                    bbox_ready         <= 1'b1;
                    state              <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (handshake) begin
                        // Beyond the frame limit the bbox is dropped and the count saturates.
                        if (room) begin
                            we                 <= 1'b1;
                            frame_to_write     <= slot;
                            offset             <= bbox_cnt[OFFSET_WIDTH:1];
                            half_sel           <= bbox_cnt[0];
                            end_pointers[slot] <= bbox_cnt + 1'b1;
                            bbox_cnt           <= bbox_cnt + 1'b1;
                        end
`ifdef OFLOW_FSM_WRITE_OVERFLOW_EN
                        if (!room) begin
                            overflow <= 1'b1;
                        end
`endif
                        if (bbox_last) begin
                            bbox_ready <= 1'b0;
                            done_write <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_oflow_fsm_write.sv
// Self-checking bench for oflow_fsm_write: directed frame table, random frames, reset abort.
// The frame model tracks slots and end pointers as plain integers per stored frame.
`timescale 1ns/1ps
`default_nettype none

module tb_oflow_fsm_write;
    import oflow_MEM_buffer_define::*;

    logic                                   clk = 1'b0;
    logic                                   reset_N = 1'b0;
    logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_num = '0;
    logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames = 3'd1;
    logic                                   start_write = 1'b0;
    logic                                   bbox_valid = 1'b0;
    logic                                   bbox_last = 1'b0;
    logic                                   bbox_ready;
    logic                                   we;
    logic [SLOT_WIDTH-1:0]                  frame_to_write;
    logic [OFFSET_WIDTH-1:0]                offset;
    logic                                   half_sel;
    logic [ADDR_WIDTH-1:0]                  end_pointers [NUM_SLOTS];
    logic                                   done_write;
    logic                                   overflow;

    oflow_fsm_write dut (
        .clk                   (clk),
        .reset_N               (reset_N),
        .frame_num             (frame_num),
        .num_of_history_frames (num_of_history_frames),
        .start_write           (start_write),
        .bbox_valid            (bbox_valid),
        .bbox_last             (bbox_last),
        .bbox_ready            (bbox_ready),
        .we                    (we),
        .frame_to_write        (frame_to_write),
        .offset                (offset),
        .half_sel              (half_sel),
        .end_pointers          (end_pointers),
        .done_write            (done_write),
        .overflow              (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int m_slot = 0;
    int m_ep [NUM_SLOTS];
    bit ovf_en = 1'b0;

    typedef struct {
        int fnum;
        int nh;
        int n;
        int mode;
        int inj;
        int exp_slot;
        int exp_ep;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eps(input string tag);
        for (int i = 0; i < NUM_SLOTS; i++) begin
            chk($sformatf("%s end_pointers[%0d]", tag, i), 32'(end_pointers[i]), 32'(m_ep[i]));
        end
    endtask

    // mode: 0 = valid every cycle, 1 = valid toggling 1/0, 2 = random valid
    task automatic run_frame(input int fnum, input int nh, input int n, input int mode,
                             input int inj, output int got_slot, output int got_ep);
        int exp_slot;
        int idx;
        int cyc;
        bit v;
        bit exp_ovf;
        exp_slot = (fnum == 0) ? 0 : (m_slot + 1) % (nh + 1);
        frame_num             = 8'(fnum);
        num_of_history_frames = 3'(nh);
        bbox_valid            = 1'b0;
        bbox_last             = 1'b0;
        start_write           = 1'b1;
        cycle();
        start_write = 1'b0;
        chk("ready_in_clear", 32'(bbox_ready), 32'd0);
        num_of_history_frames = 3'($urandom_range(1, 4));
        bbox_valid = 1'b1;
        bbox_last  = 1'b1;
        cycle();
        m_slot         = exp_slot;
        m_ep[exp_slot] = 0;
        chk("ready_in_write", 32'(bbox_ready), 32'd1);
        chk("we_after_clear", 32'(we), 32'd0);
        chk("overflow_cleared", 32'(overflow), 32'd0);
        chk("no_done_on_clear_last", 32'(done_write), 32'd0);
        check_eps("clear");
        got_slot = -1;
        idx      = 0;
        cyc      = 0;
        exp_ovf  = 1'b0;
        while (idx < n && cyc < 400) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            start_write = (inj != 0) && (cyc == 1);
            bbox_valid  = v;
            bbox_last   = v ? (idx == n - 1) : 1'($urandom_range(0, 1));
            cycle();
            start_write = 1'b0;
            if (v) begin
                if (idx < MAX_BBOX_PER_FRAME) begin
                    chk("we_after_hs", 32'(we), 32'd1);
                    chk("frame_to_write", 32'(frame_to_write), 32'(exp_slot));
                    chk("offset", 32'(offset), 32'(idx / 2));
                    chk("half_sel", 32'(half_sel), 32'(idx % 2));
                    m_ep[exp_slot] = idx + 1;
                    if (got_slot < 0) got_slot = int'(frame_to_write);
                end else begin
                    chk("we_dropped", 32'(we), 32'd0);
                    exp_ovf = ovf_en;
                end
                idx++;
            end else begin
                chk("we_idle_cycle", 32'(we), 32'd0);
            end
            chk("overflow", 32'(overflow), 32'(exp_ovf));
            chk("done_write", 32'(done_write), 32'(idx == n));
            chk("bbox_ready", 32'(bbox_ready), 32'(idx != n));
            check_eps("write");
            cyc++;
        end
        chk("frame_completed", 32'(idx), 32'(n));
        bbox_valid = 1'b0;
        bbox_last  = 1'b0;
        got_ep     = int'(end_pointers[exp_slot]);
        cycle();
        chk("done_one_cycle", 32'(done_write), 32'd0);
        chk("we_in_idle", 32'(we), 32'd0);
        chk("ready_in_idle", 32'(bbox_ready), 32'd0);
    endtask

    initial begin
        int gs;
        int ge;
        int nh;
        int fnum;
        int n;
`ifdef OFLOW_FSM_WRITE_OVERFLOW_EN
        ovf_en = 1'b1;
`endif
        for (int i = 0; i < NUM_SLOTS; i++) m_ep[i] = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_ready", 32'(bbox_ready), 32'd0);
        chk("rst_done", 32'(done_write), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_half", 32'(half_sel), 32'd0);
        chk("rst_offset", 32'(offset), 32'd0);
        chk("rst_ftw", 32'(frame_to_write), 32'd0);
        check_eps("rst");
        reset_N = 1'b1;
        cycle();

        tbl[0] = '{12, 3,  9, 0, 0, 1,  9};
        tbl[1] = '{13, 3,  5, 0, 0, 2,  5};
        tbl[2] = '{14, 3,  7, 1, 0, 3,  7};
        tbl[3] = '{15, 3,  3, 0, 0, 0,  3};
        tbl[4] = '{16, 3,  4, 2, 0, 1,  4};
        tbl[5] = '{17, 3, 34, 0, 0, 2, 32};
        tbl[6] = '{18, 3,  1, 0, 1, 3,  1};
        tbl[7] = '{19, 3,  2, 0, 0, 0,  2};
        for (int t = 0; t < 8; t++) begin
            run_frame(tbl[t].fnum, tbl[t].nh, tbl[t].n, tbl[t].mode, tbl[t].inj, gs, ge);
            chk($sformatf("tbl%0d_slot", t), 32'(gs), 32'(tbl[t].exp_slot));
            chk($sformatf("tbl%0d_end_ptr", t), 32'(ge), 32'(tbl[t].exp_ep));
        end

        for (int f = 0; f < 12; f++) begin
            nh   = $urandom_range((m_slot < 1) ? 1 : m_slot, 4);
            fnum = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 255);
            n    = $urandom_range(1, 40);
            run_frame(fnum, nh, n, $urandom_range(0, 2), 0, gs, ge);
            chk("rand_end_ptr", 32'(ge), 32'((n > MAX_BBOX_PER_FRAME) ? MAX_BBOX_PER_FRAME : n));
        end

        // Reset in the middle of a frame: everything clears at once, no completion pulse.
        frame_num             = 8'd20;
        num_of_history_frames = 3'd3;
        start_write           = 1'b1;
        cycle();
        start_write = 1'b0;
        cycle();
        for (int i = 0; i < 4; i++) begin
            bbox_valid = 1'b1;
            bbox_last  = 1'b0;
            cycle();
        end
        chk("pre_reset_we", 32'(we), 32'd1);
        #2;
        reset_N = 1'b0;
        #1;
        for (int i = 0; i < NUM_SLOTS; i++) m_ep[i] = 0;
        m_slot = 0;
        chk("async_we", 32'(we), 32'd0);
        chk("async_ready", 32'(bbox_ready), 32'd0);
        chk("async_offset", 32'(offset), 32'd0);
        chk("async_half", 32'(half_sel), 32'd0);
        chk("async_ftw", 32'(frame_to_write), 32'd0);
        check_eps("async");
        bbox_valid = 1'b1;
        bbox_last  = 1'b1;
        repeat (3) begin
            cycle();
            chk("no_done_in_reset", 32'(done_write), 32'd0);
        end
        bbox_valid = 1'b0;
        bbox_last  = 1'b0;
        reset_N    = 1'b1;
        cycle();
        chk("no_done_after_reset", 32'(done_write), 32'd0);
        run_frame(0, 3, 3, 0, 0, gs, ge);
        chk("post_reset_slot", 32'(gs), 32'd0);
        chk("post_reset_end_ptr", 32'(ge), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
